video_sync_out: RTL
===================

# video_sync_out

Registered output stage that sits directly downstream of the colour-space converter (`vga_space`) and drives the VGA/YPbPr connector pins. It aligns colour with sync and blank through a fixed two-stage pipeline, forces blanking levels that match the selected colour space, and generates a measured composite sync. It can also insert that sync onto the luma (green) channel for component output.

## Interface
Parameters:
- HCNT_W, 9, width of the hsync-width counter (saturating, max 2^HCNT_W-1 pixels)

Ports:
- clk  in  1  video clock
- reset_n  in  1  asynchronous, active-low reset
- ce_pix  in  1  pixel clock enable; all state advances only when high
- ypbpr_en  in  1  outputs carry YPbPr from the converter (R=Pr, G=Y, B=Pb)
- ypbpr_full  in  1  full-range YPbPr (selects the blank-level set)
- sog_en  in  1  insert composite sync on the G channel (only when ypbpr_en=1)
- r_in, g_in, b_in  in  6 each  pixel colour from the converter
- hs_in, vs_in  in  1 each  active-high sync, same cycle as colour
- de_in  in  1  active-high display enable
- vga_r, vga_g, vga_b  out  6 each  registered pin colour
- vga_hs  out  1  registered hsync, active-low at the pin
- vga_vs  out  1  registered vsync, active-low at the pin; driven 1 when ypbpr_en
- vga_cs  out  1  registered composite sync, active-low
- hs_width  out  HCNT_W  last measured hsync width in pixels

## Operation
- Stage 1 registers all inputs when ce_pix=1: colour, hs, vs, de, and the previous hs (hs_d) for edge detection.
- Hsync width measurement uses a counter (hcnt):
  - Clears to 1 on an hs rising edge.
  - Increments while hs is high, saturating at all-ones.
  - On the hs falling edge, hcnt is latched into hs_width.
- Composite sync, active-high internally:
  - vs=0: cs = hs.
  - vs=1 (serration): cs = 1, except for a window of hs_width pixels starting at each hs rising edge, where cs = 0. A serration counter loads hs_width at the rising edge and decrements to 0.
  - If hs_width=0 (nothing measured yet), the window is empty and cs stays 1 for the whole vs period.
- Blank levels, applied when stage-1 de=0:
  - RGB mode: 0/0/0.
  - YPbPr limited: Y=4, Pb=Pr=32.
  - YPbPr full: Y=0, Pb=Pr=32.
- Sync on green: when ypbpr_en & sog_en & cs, vga_g=0, overriding both colour and blank level. R and B are not affected.
- Pin polarity:
  - vga_hs = ~hs, vga_vs = ~vs, vga_cs = ~cs.
  - When ypbpr_en=1, vga_hs = ~cs and vga_vs = 1, so component sync goes on the hsync pin.
- Mode inputs (ypbpr_en, ypbpr_full, sog_en) are sampled in stage 2 without synchronisation. They are quasi-static, and a change takes effect at the next ce_pix.

## Timing
- Latency is 2 ce_pix cycles, input to pins, identical for colour, hs, vs, cs and blanking.
- When ce_pix=0, every register holds its value.
- Reset (asynchronous assert, release on a clk edge) gives:
  - vga_r/g/b = 0, vga_hs = vga_vs = vga_cs = 1.
  - hs_width = 0, counters = 0, pipeline de = 0.
- Reset mid-frame: outputs return to their reset values immediately. Width measurement restarts, so hs_width = 0 until the first complete hsync pulse.
- Saturation: an hs pulse longer than 2^HCNT_W-1 pixels reports all-ones. The serration window is then capped at that value.
- hs and vs rising in the same cycle: the serration window starts in that cycle using the previously latched hs_width.
- An hs pulse of 1 pixel gives hs_width=1 and a 1-pixel serration window.

## Test plan
- Reset: assert reset_n=0 mid-line -> all colour pins 0, vga_hs/vs/cs=1, hs_width=0 in the same cycle; after release, all remain so until 2 ce_pix cycles after the first input.
- Latency/RGB: ypbpr_en=0, de=1, r/g/b=63/21/5 with ce_pix every 2nd clk -> pins show 63/21/5 exactly 2 ce_pix later; de=0 -> 0/0/0 with the same latency.
- Width measure: hs high for 44 pixels -> hs_width=44 after the falling edge; hs high for 600 pixels with HCNT_W=9 -> 511.
- Serration: hs_width=44, vs=1, hs rising -> vga_cs high (deasserted) for 44 pixels after the edge, low elsewhere in the line; vs=0 -> vga_cs = ~hs.
- YPbPr blank/SOG: ypbpr_en=1, ypbpr_full=0, de=0, cs=0 -> G/B/R = 4/32/32; sog_en=1 with cs=1 -> G=0, R/B unchanged; ypbpr_full=1 -> blank G=0.
- Pin routing: ypbpr_en=1 -> vga_vs constantly 1 and vga_hs equals vga_cs every cycle.

Source files
------------

// File: rtl/video_sync_out.sv
// video_sync_out: two-stage registered VGA/YPbPr pin driver.
// Stage 1 captures the converter outputs and measures hsync width; stage 2
// applies blank levels, sync-on-green and pin polarity. Both stages advance
// only on ce_pix, so colour, syncs and blanking share one fixed latency.
module video_sync_out #(
  parameter int HCNT_W = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic              ypbpr_en,
  input  logic              ypbpr_full,
  input  logic              sog_en,
  input  logic [5:0]        r_in,
  input  logic [5:0]        g_in,
  input  logic [5:0]        b_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              de_in,
  output logic [5:0]        vga_r,
  output logic [5:0]        vga_g,
  output logic [5:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_cs,
  output logic [HCNT_W-1:0] hs_width
);

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } pix_t;

  localparam logic [HCNT_W-1:0] CNT_MAX = '1;
  localparam logic [HCNT_W-1:0] CNT_ONE = HCNT_W'(1);

  pix_t              s1;
  logic              hs_d;
  logic              hs_rise, hs_fall;
  logic [HCNT_W-1:0] hcnt;
  logic [HCNT_W-1:0] scnt, scnt_nxt;
  logic              win;
  logic              cs;
  logic [5:0]        r_o, g_o, b_o;

  assign hs_rise = s1.hs & ~hs_d;
  assign hs_fall = ~s1.hs & hs_d;

  // Stage 1: capture the pixel and keep the previous hs for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= '0;
      hs_d <= 1'b0;
    end else if (ce_pix) begin
      s1   <= '{r: r_in, g: g_in, b: b_in, hs: hs_in, vs: vs_in, de: de_in};
      hs_d <= s1.hs;
    end
  end

  // Hsync width: count high pixels (saturating), latch the count at the fall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt     <= '0;
      hs_width <= '0;
    end else if (ce_pix) begin
      if (hs_rise)
        hcnt <= CNT_ONE;
      else if (s1.hs && hcnt != CNT_MAX)
        hcnt <= hcnt + CNT_ONE;
      if (hs_fall)
        hs_width <= hcnt;
    end
  end

  // Serration window: hs_width pixels from each rise, the rise pixel included
  always_comb begin
    if (hs_rise) begin
      win      = (hs_width != '0);
      scnt_nxt = win ? hs_width - CNT_ONE : '0;
    end else begin
      win      = (scnt != '0);
      scnt_nxt = win ? scnt - CNT_ONE : '0;
    end
    cs = s1.vs ? ~win : s1.hs;
  end

  // Serration down-counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    scnt <= '0;
    else if (ce_pix) scnt <= scnt_nxt;
  end

  // Blank levels follow the colour space; SOG pulls luma to 0 during sync
  always_comb begin
    r_o = s1.r;
    g_o = s1.g;
    b_o = s1.b;
    if (!s1.de) begin
      r_o = ypbpr_en ? 6'd32 : 6'd0;
      b_o = ypbpr_en ? 6'd32 : 6'd0;
      g_o = (ypbpr_en && !ypbpr_full) ? 6'd4 : 6'd0;
    end
    if (ypbpr_en && sog_en && cs)
      g_o = 6'd0;
  end

  // Stage 2: pin registers; component mode routes composite sync to hsync pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_cs <= 1'b1;
    end else if (ce_pix) begin
      vga_r  <= r_o;
      vga_g  <= g_o;
      vga_b  <= b_o;
      vga_hs <= ypbpr_en ? ~cs : ~s1.hs;
      vga_vs <= ypbpr_en ? 1'b1 : ~s1.vs;
      vga_cs <= ~cs;
    end
  end

endmodule
